// File: rtl/dac_wave_player_if.sv
// Bus between Ctr_UART / sequencer and the DAC waveform player: table load, playback control, DAC pins.
interface dac_wave_player_if #(
    parameter int ND_DAC = 14,
    parameter int NA_DAC = 8,
    parameter int NDIV   = 16
);
    logic              wr_en;
    logic [NA_DAC-1:0] wr_addr;
    logic [ND_DAC-1:0] wr_data;
    logic [NA_DAC-1:0] play_len;
    logic [NDIV-1:0]   div;
    logic              loop_en;
    logic              start;
    logic              stop;
    logic [ND_DAC-1:0] dac_data;
    logic              dac_clk;
    logic [NA_DAC-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic              wr_err;
    logic [1:0]        dbg_state;

    // Control side is level based: start is taken when sampled high in IDLE/DONE,
    // stop wins over start, wr_en writes one sample per high cycle outside PLAY.
    modport master (
        output wr_en, wr_addr, wr_data, play_len, div, loop_en, start, stop,
        input  dac_data, dac_clk, rd_addr, busy, done, wr_err, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, play_len, div, loop_en, start, stop,
        output dac_data, dac_clk, rd_addr, busy, done, wr_err, dbg_state
    );
endinterface

// File: rtl/dac_wave_player.sv
// Replays a 256-entry signed waveform table to the excitation DAC at a programmable
// sample period, single-shot or looping, with offset-binary output coding.
module dac_wave_player #(
    parameter int                ND_DAC   = 14,
    parameter int                NA_DAC   = 8,
    parameter int                NDIV     = 16,
    parameter logic [ND_DAC-1:0] MIDSCALE = 14'h2000
) (
    input  logic               clk,
    input  logic               rst,
    dac_wave_player_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ND_DAC-1:0] r_mem [0:(1<<NA_DAC)-1];
    logic [ND_DAC-1:0] r_ram_q;

    logic [NA_DAC-1:0] r_len;
    logic [NDIV-1:0]   r_div;
    logic              r_loop;
    logic [NDIV-1:0]   r_cnt;
    logic [NA_DAC-1:0] r_fetch_idx;
    logic              r_first;
    logic [ND_DAC-1:0] r_dac_data;
    logic              r_dac_clk;
    logic [NA_DAC-1:0] r_rd_addr;
    logic              r_wr_err;

    logic [NDIV-1:0]   w_div_clamped;
    logic [NDIV-1:0]   w_half;
    logic              w_start_ok;
    logic              w_cnt_pre;
    logic              w_cnt_end;
    logic              w_last;
    logic              w_finish;

    assign w_div_clamped = (bus.div == '0) ? NDIV'(1) : bus.div;
    assign w_half        = NDIV'(({1'b0, r_div} + (NDIV+1)'(1)) >> 1);
    assign w_start_ok    = bus.start && !bus.stop && (r_state != S_PLAY);
    assign w_cnt_pre     = (r_cnt == (r_div - NDIV'(1)));
    assign w_cnt_end     = (r_cnt == r_div);
    // r_first marks the pre-roll period before sample 0 is on the pins.
    assign w_last        = !r_first && (r_rd_addr == r_len);
    assign w_finish      = (r_state == S_PLAY) && w_cnt_end && w_last && !r_loop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_nxt = S_PLAY;
                S_PLAY:  if (w_finish)  w_state_nxt = S_DONE;
                S_DONE:  if (bus.start) w_state_nxt = S_PLAY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Table: writes blocked during playback, reads issued one clock before each update.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (r_state != S_PLAY)) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        if ((r_state == S_PLAY) && w_cnt_pre) begin
            r_ram_q <= r_mem[r_fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len       <= '0;
            r_div       <= NDIV'(1);
            r_loop      <= 1'b0;
            r_cnt       <= '0;
            r_fetch_idx <= '0;
            r_first     <= 1'b0;
            r_dac_data  <= MIDSCALE;
            r_dac_clk   <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_err    <= 1'b0;
        end else if (bus.stop) begin
            r_cnt       <= '0;
            r_fetch_idx <= '0;
            r_first     <= 1'b0;
            r_dac_data  <= MIDSCALE;
            r_dac_clk   <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_err    <= 1'b0;
        end else if (w_start_ok) begin
            // Counter starts at D-1 so the fetch of index 0 and its display land
            // on the 1st and 2nd edges after start.
            r_len       <= bus.play_len;
            r_div       <= w_div_clamped;
            r_loop      <= bus.loop_en;
            r_cnt       <= w_div_clamped - NDIV'(1);
            r_fetch_idx <= '0;
            r_first     <= 1'b1;
            r_dac_clk   <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_err    <= 1'b0;
        end else if (r_state == S_PLAY) begin
            if (bus.wr_en) begin
                r_wr_err <= 1'b1;
            end
            if (w_cnt_end) begin
                r_cnt     <= '0;
                r_dac_clk <= 1'b0;
                if (!w_finish) begin
                    r_dac_data  <= {~r_ram_q[ND_DAC-1], r_ram_q[ND_DAC-2:0]};
                    r_rd_addr   <= r_fetch_idx;
                    r_fetch_idx <= (r_fetch_idx == r_len) ? '0 : r_fetch_idx + NA_DAC'(1);
                    r_first     <= 1'b0;
                end
            end else begin
                r_cnt     <= r_cnt + NDIV'(1);
                r_dac_clk <= !r_first && ((r_cnt + NDIV'(1)) >= w_half);
            end
        end
    end

    assign bus.dac_data  = r_dac_data;
    assign bus.dac_clk   = r_dac_clk;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.busy      = (r_state == S_PLAY);
    assign bus.done      = (r_state == S_DONE);
    assign bus.wr_err    = r_wr_err;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_dac_wave_player.sv
// Bench for dac_wave_player: directed and randomized playbacks checked cycle by cycle
// against a sample-sequence model derived from the table contents.
module tb_dac_wave_player;
    localparam int             W   = 14;
    localparam logic [W-1:0]   MID = 14'h2000;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dac_wave_player_if bus ();

    dac_wave_player dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_mem [256];
    logic [W-1:0] pre_data;
    int           cur_len;
    int           cur_p;
    int           cur_wr_k;
    bit           cur_loop;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // sample value s (signed) is presented as s + 8192
    function automatic logic [W-1:0] to_code(input logic [W-1:0] s);
        int v;
        v = int'($signed(s)) + 8192;
        return W'(v);
    endfunction

    task automatic write_word(input logic [7:0] addr, input logic [W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " dac_data"}, 32'(bus.dac_data), 32'(MID));
        chk({tag, " dac_clk"},  32'(bus.dac_clk),  32'd0);
        chk({tag, " rd_addr"},  32'(bus.rd_addr),  32'd0);
        chk({tag, " busy"},     32'(bus.busy),     32'd0);
        chk({tag, " done"},     32'(bus.done),     32'd0);
        chk({tag, " wr_err"},   32'(bus.wr_err),   32'd0);
    endtask

    // k = clock edges since the edge that sampled start
    task automatic check_cycle(input int k);
        logic [W-1:0] e_d;
        logic [7:0]   e_ra;
        logic         e_ck, e_b, e_dn, e_we;
        int           m, j, ph;
        e_we = (cur_wr_k >= 0) && (k > cur_wr_k);
        if (k < 2) begin
            e_d = pre_data; e_ck = 1'b0; e_ra = 8'd0; e_b = 1'b1; e_dn = 1'b0;
        end else begin
            m  = k - 2;
            j  = m / cur_p;
            ph = m % cur_p;
            if (!cur_loop && (j > cur_len)) begin
                e_d = exp_q[cur_len]; e_ck = 1'b0; e_ra = 8'(cur_len); e_b = 1'b0; e_dn = 1'b1;
            end else begin
                e_d  = exp_q[j];
                e_ck = (ph >= cur_p / 2) && (ph > 0);
                e_ra = 8'(j % (cur_len + 1));
                e_b  = 1'b1;
                e_dn = 1'b0;
            end
        end
        chk($sformatf("dac_data k=%0d", k), 32'(bus.dac_data), 32'(e_d));
        chk($sformatf("dac_clk k=%0d", k),  32'(bus.dac_clk),  32'(e_ck));
        chk($sformatf("rd_addr k=%0d", k),  32'(bus.rd_addr),  32'(e_ra));
        chk($sformatf("busy k=%0d", k),     32'(bus.busy),     32'(e_b));
        chk($sformatf("done k=%0d", k),     32'(bus.done),     32'(e_dn));
        chk($sformatf("wr_err k=%0d", k),   32'(bus.wr_err),   32'(e_we));
    endtask

    // Pulse start, scramble the control inputs, then check n cycles.
    task automatic play(input int len, input int dv, input bit loop, input int n,
                        input int stop_k, input int wr_k);
        int nsamp;
        cur_len  = len;
        cur_p    = ((dv < 1) ? 1 : dv) + 1;
        cur_loop = loop;
        cur_wr_k = wr_k;
        exp_q.delete();
        nsamp = loop ? (n / cur_p + 1) : (len + 1);
        for (int j = 0; j < nsamp; j++) exp_q.push_back(to_code(model_mem[j % (len + 1)]));
        bus.play_len = 8'(len);
        bus.div      = 16'(dv);
        bus.loop_en  = loop;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.div      = 16'd9;
        bus.play_len = ~8'(len);
        bus.loop_en  = ~loop;
        for (int k = 0; k < n; k++) begin
            check_cycle(k);
            if (k == wr_k) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 8'd1;
                bus.wr_data = 14'h0155;
            end
            if (k == stop_k) bus.stop = 1'b1;
            tick();
            bus.wr_en = 1'b0;
            if (k == stop_k) begin
                bus.stop = 1'b0;
                check_idle($sformatf("stop k=%0d", k));
                pre_data = MID;
                return;
            end
        end
        if (!loop) pre_data = exp_q[len];
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.play_len = '0; bus.div = 16'd3; bus.loop_en = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;
        cur_wr_k = -1;
        pre_data = MID;

        tick(); tick();
        check_idle("reset");
        #2 rst = 1'b1;
        tick();
        check_idle("post_reset");

        // basic single shot, D=3
        write_word(8'd0, 14'h2000);
        write_word(8'd1, 14'h0000);
        write_word(8'd2, 14'h1FFF);
        write_word(8'd3, 14'h3FFF);
        play(3, 3, 1'b0, 2 + 16 + 3, -1, -1);

        // looping at D=1, stopped mid-sequence
        play(3, 1, 1'b1, 20, 13, -1);

        // div=0 clamps to 1; div changed to 9 during play is ignored
        play(1, 0, 1'b1, 16, 11, -1);

        // play_len=0 looping: constant output, dac_clk keeps toggling
        play(0, 2, 1'b1, 14, 12, -1);

        // write during PLAY is dropped and flagged; next start clears the flag
        play(3, 3, 1'b0, 21, -1, 5);
        chk("wr_err_sticky", 32'(bus.wr_err), 32'd1);
        play(3, 3, 1'b0, 21, -1, -1);

        // randomized tables and settings
        for (int r = 0; r < 6; r++) begin
            int len;
            int dv;
            bit lp;
            for (int a = 0; a < 16; a++) write_word(8'(a), 14'($urandom));
            len = $urandom_range(0, 15);
            dv  = $urandom_range(0, 4);
            lp  = 1'($urandom_range(0, 1));
            if (lp) play(len, dv, lp, 60, $urandom_range(0, 59), -1);
            else    play(len, dv, lp, 2 + (len + 1) * (((dv < 1) ? 1 : dv) + 1) + 3, -1,
                         ($urandom_range(0, 1) != 0) ? 1 : -1);
        end

        // asynchronous reset in the middle of playback
        bus.play_len = 8'd3; bus.div = 16'd3; bus.loop_en = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("busy_before_rst", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1 check_idle("async_rst");
        #2 rst = 1'b1;
        tick();
        check_idle("after_rst");

        // start and stop together from IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_idle("start_stop");
        tick();
        check_idle("start_stop_hold");
        pre_data = MID;

        // full-depth ramp, then restart from DONE
        for (int i = 0; i < 256; i++) write_word(8'(i), 14'(i - 128));
        play(255, 1, 1'b0, 2 + 512 + 3, -1, -1);
        chk("ramp_done", 32'(bus.done), 32'd1);
        play(255, 1, 1'b0, 10, 9, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
